// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default sizing for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int DEF_ON_CYCLES  = 8;
  localparam int DEF_OFF_CYCLES = 8;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_PEND_W     = 3;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; rise is high on the cycle d first reads 1.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON/OFF level pulses, queuing events that arrive mid-pulse.
// Define STRETCH_EDGE_DETECT_EN to count only 0->1 transitions of pulse_in as events.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              stretched_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic ev;

`ifdef STRETCH_EDGE_DETECT_EN
  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (pulse_in),
    .rise (ev)
  );
`else
  assign ev = pulse_in;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, busy_q;
  logic              enq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    enq     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        enq = ev;
        if (cnt_q == ON_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          // A coincident event replaces the dequeued one, so pending is left alone.
          if (pend_q != '0) begin
            state_d = ON;
            if (!ev) pend_d = pend_q - 1'b1;
          end else if (ev) begin
            state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          enq   = ev;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enq) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign stretched_out = out_q;
  assign busy          = busy_q;
  assign pending       = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a behavioural model predicts each cycle's outputs.
module tb_pulse_stretcher;

  localparam int ON  = 8;
  localparam int OFF = 8;
  localparam int PW  = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pulse_in;
  logic          stretched_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .CNT_W      (4),
    .PEND_W     (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pulse_in      (pulse_in),
    .stretched_out (stretched_out),
    .busy          (busy),
    .pending       (pending),
    .overflow      (overflow)
  );

  typedef struct packed {
    logic          out;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses, n_high;
  bit prev_out_s;

  // Reference model state: remaining cycles in the current phase
  bit m_act, m_on, m_ovf, m_prev;
  int m_rem, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_act = 0; m_on = 0; m_ovf = 0; m_prev = 0; m_rem = 0; m_pend = 0;
  endfunction

  function automatic void model_enq(input bit ev);
    if (ev) begin
      if (m_pend == PMAX) m_ovf = 1;
      else                m_pend++;
    end
  endfunction

  function automatic void model_step(input bit p);
    bit   ev;
    exp_t e;
`ifdef STRETCH_EDGE_DETECT_EN
    ev = p & ~m_prev;
    m_prev = p;
`else
    ev = p;
`endif
    if (!m_act) begin
      if (ev) begin m_act = 1; m_on = 1; m_rem = ON; end
    end else if (m_on) begin
      model_enq(ev);
      if (m_rem == 1) begin m_on = 0; m_rem = OFF; end
      else m_rem--;
    end else begin
      if (m_rem == 1) begin
        if (m_pend > 0) begin
          m_on = 1; m_rem = ON;
          if (!ev) m_pend--;
        end else if (ev) begin
          m_on = 1; m_rem = ON;
        end else begin
          m_act = 0;
        end
      end else begin
        m_rem--;
        model_enq(ev);
      end
    end
    e.out  = m_act & m_on;
    e.busy = m_act;
    e.pend = PW'(m_pend);
    e.ovf  = m_ovf;
    sb_q.push_back(e);
  endfunction

  task automatic tick(input bit p);
    exp_t e;
    pulse_in = p;
    model_step(p);
    @(posedge clk);
    #1;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("out", stretched_out, e.out);
      check("busy", busy, e.busy);
      check("pending", pending, e.pend);
      check("overflow", overflow, e.ovf);
    end
    if (stretched_out && !prev_out_s) n_pulses++;
    if (stretched_out) n_high++;
    prev_out_s = stretched_out;
  endtask

  task automatic do_reset(input string tag);
    pulse_in = 1'b0;
    rst = 1'b1;
    #1;
    check({tag, "_out"}, stretched_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pend"}, pending, 0);
    check({tag, "_ovf"}, overflow, 0);
    model_reset();
    sb_q.delete();
    prev_out_s = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (busy && k < 400) begin
      tick(1'b0);
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic start_test();
    n_pulses = 0;
    n_high = 0;
  endtask

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    prev_out_s = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", stretched_out, 0);
    check("reset_busy", busy, 0);
    check("reset_pend", pending, 0);
    check("reset_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-ON
    tick(1'b1); tick(1'b0); tick(1'b0);
    #2;
    do_reset("async_rst");
    repeat (3) tick(1'b0);
    check("post_rst_busy", busy, 0);

    // Single event
    start_test();
    tick(1'b1);
    drain("single");
    check("single_pulses", n_pulses, 1);
    check("single_high", n_high, ON);

    // Three queued events
    start_test();
    tick(1'b1); tick(1'b0);
    tick(1'b1);
    check("queue_pend1", pending, 1);
    tick(1'b0);
    tick(1'b1);
    check("queue_pend2", pending, 2);
    drain("queue");
    check("queue_pulses", n_pulses, 3);
    check("queue_high", n_high, 3 * ON);
    check("queue_pend_end", pending, 0);

    // Event on last OFF cycle with nothing queued
    start_test();
    tick(1'b1);
    repeat (ON + OFF - 1) tick(1'b0);
    tick(1'b1);
    check("lastoff_on", stretched_out, 1);
    check("lastoff_pend", pending, 0);
    drain("lastoff");
    check("lastoff_pulses", n_pulses, 2);

    // Simultaneous event and dequeue with pending=2
    start_test();
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    repeat (ON + OFF - 5) tick(1'b0);
    tick(1'b1);
    check("sim_pend", pending, 2);
    check("sim_on", stretched_out, 1);
    check("sim_ovf", overflow, 0);
    drain("sim");
    check("sim_pulses", n_pulses, 4);

    // Queue overflow
    start_test();
`ifdef STRETCH_EDGE_DETECT_EN
    repeat (17) begin tick(1'b1); tick(1'b0); end
    check("ovf_pend", pending, PMAX);
    check("ovf_flag", overflow, 1);
    drain("ovf");
    check("ovf_pulses", n_pulses, 10);
`else
    repeat (9) tick(1'b1);
    check("ovf_pend", pending, PMAX);
    check("ovf_flag", overflow, 1);
    drain("ovf");
    check("ovf_pulses", n_pulses, 8);
`endif
    check("ovf_sticky", overflow, 1);
    @(negedge clk);
    do_reset("ovf_clear");

    // Input held high for 20 cycles
    start_test();
    repeat (20) tick(1'b1);
`ifdef STRETCH_EDGE_DETECT_EN
    check("hold_pend", pending, 0);
    check("hold_ovf", overflow, 0);
    drain("hold");
    check("hold_pulses", n_pulses, 1);
`else
    check("hold_pend", pending, PMAX);
    check("hold_ovf", overflow, 1);
    drain("hold");
    check("hold_pulses", n_pulses, 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
